t01_ai_placement_scheduler: RTL

//  Sequences the AI feature extractor over every candidate placement (rotation x column) of the current piece.
//  Per candidate: requests the placed grid from the grid builder, runs extraction, forms a weighted score, keeps the best.

---
 rtl/t01_ai_pkg.sv | 24 ++
 rtl/t01_ai_score_calc.sv | 34 +++
 rtl/t01_ai_placement_scheduler.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/t01_ai_pkg.sv
// Shared types and default constants for the AI placement blocks.
// Weights are magnitudes; the score calculator applies the signs.
package t01_ai_pkg;

    localparam int DEF_NUM_ROT  = 4;
    localparam int DEF_NUM_COL  = 10;
    localparam int DEF_SCORE_W  = 20;
    localparam int DEF_W_LINES  = 76;
    localparam int DEF_W_HEIGHT = 51;
    localparam int DEF_W_HOLES  = 36;
    localparam int DEF_W_BUMP   = 18;

    localparam logic signed [DEF_SCORE_W-1:0] SCORE_MIN = {1'b1, {(DEF_SCORE_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_EXTRACT,
        S_SCORE,
        S_NEXT,
        S_DONE
    } state_t;

endpackage

// File: rtl/t01_ai_score_calc.sv
// Combinational weighted placement score: lines reward, height/holes/bumpiness penalise.
// Latency 0; no flow control (pure function of the four features).
module t01_ai_score_calc
    import t01_ai_pkg::*;
#(
    parameter int SCORE_W  = DEF_SCORE_W,
    parameter int W_LINES  = DEF_W_LINES,
    parameter int W_HEIGHT = DEF_W_HEIGHT,
    parameter int W_HOLES  = DEF_W_HOLES,
    parameter int W_BUMP   = DEF_W_BUMP
) (
    input  logic [7:0]                i_lines_cleared,
    input  logic [7:0]                i_holes,
    input  logic [7:0]                i_bumpiness,
    input  logic [7:0]                i_height_sum,
    output logic signed [SCORE_W-1:0] o_score
);

    localparam logic signed [SCORE_W-1:0] L_W_LINES  = SCORE_W'(W_LINES);
    localparam logic signed [SCORE_W-1:0] L_W_HEIGHT = SCORE_W'(W_HEIGHT);
    localparam logic signed [SCORE_W-1:0] L_W_HOLES  = SCORE_W'(W_HOLES);
    localparam logic signed [SCORE_W-1:0] L_W_BUMP   = SCORE_W'(W_BUMP);

    logic signed [SCORE_W-1:0] w_lc, w_ho, w_bu, w_hs;

    assign w_lc = $signed({{(SCORE_W-8){1'b0}}, i_lines_cleared});
    assign w_ho = $signed({{(SCORE_W-8){1'b0}}, i_holes});
    assign w_bu = $signed({{(SCORE_W-8){1'b0}}, i_bumpiness});
    assign w_hs = $signed({{(SCORE_W-8){1'b0}}, i_height_sum});

    assign o_score = (w_lc * L_W_LINES) - (w_hs * L_W_HEIGHT)
                   - (w_ho * L_W_HOLES) - (w_bu * L_W_BUMP);

endmodule

// File: rtl/t01_ai_placement_scheduler.sv
// Scans every (rotation, column) candidate through builder and extractor, keeping the best score.
// Legal candidate costs ack + extractor latency + 2 cycles; AI_EARLY_EXIT_EN stops the scan on a 4-line clear.
module t01_ai_placement_scheduler
    import t01_ai_pkg::*;
#(
    parameter int NUM_ROT  = DEF_NUM_ROT,
    parameter int NUM_COL  = DEF_NUM_COL,
    parameter int SCORE_W  = DEF_SCORE_W,
    parameter int W_LINES  = DEF_W_LINES,
    parameter int W_HEIGHT = DEF_W_HEIGHT,
    parameter int W_HOLES  = DEF_W_HOLES,
    parameter int W_BUMP   = DEF_W_BUMP
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_plan_start,
    input  logic                      i_plan_abort,
    output logic                      o_cand_req,
    output logic [1:0]                o_cand_rot,
    output logic [3:0]                o_cand_col,
    input  logic                      i_cand_ack,
    input  logic                      i_cand_legal,
    output logic                      o_extract_start,
    output logic                      o_ofm_done,
    input  logic                      i_extract_ready,
    input  logic [7:0]                i_lines_cleared,
    input  logic [7:0]                i_holes,
    input  logic [7:0]                i_bumpiness,
    input  logic [7:0]                i_height_sum,
    output logic                      o_plan_busy,
    output logic                      o_plan_done,
    output logic                      o_best_found,
    output logic [1:0]                o_best_rot,
    output logic [3:0]                o_best_col,
    output logic signed [SCORE_W-1:0] o_best_score
);

    localparam logic [1:0] L_ROT_LAST = 2'(NUM_ROT - 1);
    localparam logic [3:0] L_COL_LAST = 4'(NUM_COL - 1);
    localparam logic signed [SCORE_W-1:0] L_SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

    state_t                    r_state, w_state_nxt;
    logic [1:0]                r_rot;
    logic [3:0]                r_col;
    logic                      r_best_found;
    logic [1:0]                r_best_rot;
    logic [3:0]                r_best_col;
    logic signed [SCORE_W-1:0] r_best_score;
    logic signed [SCORE_W-1:0] w_score;
    logic                      w_last, w_better, w_early;

    t01_ai_score_calc #(
        .SCORE_W  (SCORE_W),
        .W_LINES  (W_LINES),
        .W_HEIGHT (W_HEIGHT),
        .W_HOLES  (W_HOLES),
        .W_BUMP   (W_BUMP)
    ) u_score (
        .i_lines_cleared (i_lines_cleared),
        .i_holes         (i_holes),
        .i_bumpiness     (i_bumpiness),
        .i_height_sum    (i_height_sum),
        .o_score         (w_score)
    );

    assign w_last   = (r_rot == L_ROT_LAST) && (r_col == L_COL_LAST);
    // Strict compare: on a tie the earlier candidate in scan order stays best.
    assign w_better = !r_best_found || (w_score > r_best_score);

`ifdef AI_EARLY_EXIT_EN
    assign w_early = (i_lines_cleared == 8'd4);
`else
    assign w_early = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        o_cand_req      = 1'b0;
        o_extract_start = 1'b0;
        o_ofm_done      = 1'b0;
        o_plan_done     = 1'b0;
        o_plan_busy     = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:    if (i_plan_start) w_state_nxt = S_REQ;
            S_REQ: begin
                o_cand_req = 1'b1;
                if (i_cand_ack) w_state_nxt = i_cand_legal ? S_EXTRACT : S_NEXT;
            end
            S_EXTRACT: begin
                o_extract_start = 1'b1;
                if (i_extract_ready) w_state_nxt = S_SCORE;
            end
            S_SCORE: begin
                o_extract_start = 1'b1;
                o_ofm_done      = 1'b1;
                w_state_nxt     = w_early ? S_DONE : S_NEXT;
            end
            S_NEXT:    w_state_nxt = w_last ? S_DONE : S_REQ;
            S_DONE: begin
                o_plan_done = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default:   w_state_nxt = S_IDLE;
        endcase
        // Abort overrides every transition, including a start seen in IDLE.
        if (i_plan_abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rot        <= '0;
            r_col        <= '0;
            r_best_found <= 1'b0;
            r_best_rot   <= '0;
            r_best_col   <= '0;
            r_best_score <= L_SCORE_MIN;
        end else if (!i_plan_abort) begin
            case (r_state)
                S_IDLE: if (i_plan_start) begin
                    r_rot        <= '0;
                    r_col        <= '0;
                    r_best_found <= 1'b0;
                    r_best_rot   <= '0;
                    r_best_col   <= '0;
                    r_best_score <= L_SCORE_MIN;
                end
                S_SCORE: if (w_better) begin
                    r_best_found <= 1'b1;
                    r_best_rot   <= r_rot;
                    r_best_col   <= r_col;
                    r_best_score <= w_score;
                end
                S_NEXT: begin
                    if (r_col == L_COL_LAST) begin
                        r_col <= '0;
                        r_rot <= r_rot + 2'd1;
                    end else begin
                        r_col <= r_col + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_cand_rot   = r_rot;
    assign o_cand_col   = r_col;
    assign o_best_found = r_best_found;
    assign o_best_rot   = r_best_rot;
    assign o_best_col   = r_best_col;
    assign o_best_score = r_best_score;

endmodule
